core_wb_arbiter: RTL and testbench

Writeback arbiter for the core's single register-file write port. It accepts register writes from two producers, the ALU and the load/store unit (LSU), over valid/ready handshakes, and grants at most one per cycle. A bounded-starvation policy decides the winner. The granted write goes into a registered output stage that drives the register file's `rd_we_i`/`rd_addr_i`/`rd_data_i` directly.

---
 rtl/core_wb_arbiter.sv | 104 ++++++++++
 tb/tb_core_wb_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/core_wb_arbiter.sv
// Writeback arbiter: grants one of ALU/LSU per cycle into a registered register-file write port.
// Define CORE_WB_FAIRNESS_EN to enable the bounded-starvation counter; otherwise LSU has strict priority.
module core_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        alu_valid_i,
  output logic        alu_ready_o,
  input  logic [4:0]  alu_addr_i,
  input  logic [31:0] alu_data_i,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        rd_we_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic [3:0]  starve_cnt_o
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gen_bad_limit
    $error("core_wb_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic force_alu;

`ifdef CORE_WB_FAIRNESS_EN
  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_d, starve_cnt_q;

  assign force_alu = (starve_cnt_q == Limit);

  // Counts LSU wins only while the ALU is actually waiting; saturates at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!alu_valid_i || alu_ready_o) begin
      starve_cnt_d = 4'd0;
    end else if (lsu_ready_o && (starve_cnt_q != Limit)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_cnt_o = starve_cnt_q;
`else
  assign force_alu    = 1'b0;
  assign starve_cnt_o = 4'd0;
`endif

  always_comb begin
    alu_ready_o = 1'b0;
    lsu_ready_o = 1'b0;
    if (!rst_i) begin
      alu_ready_o = alu_valid_i && (!lsu_valid_i || force_alu);
      lsu_ready_o = lsu_valid_i && !(alu_valid_i && force_alu);
    end
  end

  logic        rd_we_d, rd_we_q;
  logic [4:0]  rd_addr_d, rd_addr_q;
  logic [31:0] rd_data_d, rd_data_q;

  // Writes to x0 still complete the handshake but never raise the write enable.
  always_comb begin
    rd_we_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (alu_ready_o) begin
      rd_addr_d = alu_addr_i;
      rd_data_d = alu_data_i;
      rd_we_d   = (alu_addr_i != 5'd0);
    end else if (lsu_ready_o) begin
      rd_addr_d = lsu_addr_i;
      rd_data_d = lsu_data_i;
      rd_we_d   = (lsu_addr_i != 5'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_we_q   <= 1'b0;
      rd_addr_q <= 5'd0;
      rd_data_q <= 32'd0;
    end else begin
      rd_we_q   <= rd_we_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_we_o   = rd_we_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed bench for core_wb_arbiter; expectations follow CORE_WB_FAIRNESS_EN when defined.
module tb_core_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_valid_i, lsu_valid_i;
  logic        alu_ready_o, lsu_ready_o;
  logic [4:0]  alu_addr_i, lsu_addr_i;
  logic [31:0] alu_data_i, lsu_data_i;
  logic        rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic [3:0]  starve_cnt_o;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

`ifdef CORE_WB_FAIRNESS_EN
  localparam bit Fair = 1'b1;
`else
  localparam bit Fair = 1'b0;
`endif

  core_wb_arbiter #(.STARVE_LIMIT(4)) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alu_valid_i  (alu_valid_i),
    .alu_ready_o  (alu_ready_o),
    .alu_addr_i   (alu_addr_i),
    .alu_data_i   (alu_data_i),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_ready_o  (lsu_ready_o),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_data_i   (lsu_data_i),
    .rd_we_o      (rd_we_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_o    (rd_data_o),
    .starve_cnt_o (starve_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic exp_alu, prev_alu;
    int unsigned phase;

    rst_i       = 1'b1;
    alu_valid_i = 1'b1;
    lsu_valid_i = 1'b1;
    alu_addr_i  = 5'd3;
    alu_data_i  = 32'h1111_1111;
    lsu_addr_i  = 5'd4;
    lsu_data_i  = 32'h2222_2222;

    // Reset with both requests pending.
    repeat (2) next_cycle();
    @(negedge clk_i);
    check_eq("rst_alu_ready", 32'(alu_ready_o), 32'd0);
    check_eq("rst_lsu_ready", 32'(lsu_ready_o), 32'd0);
    check_eq("rst_we", 32'(rd_we_o), 32'd0);
    check_eq("rst_addr", 32'(rd_addr_o), 32'd0);
    check_eq("rst_data", rd_data_o, 32'd0);
    check_eq("rst_cnt", 32'(starve_cnt_o), 32'd0);

    next_cycle();
    rst_i       = 1'b0;
    alu_valid_i = 1'b0;
    lsu_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("idle_we", 32'(rd_we_o), 32'd0);

    // Single ALU source.
    next_cycle();
    alu_valid_i = 1'b1;
    alu_addr_i  = 5'd5;
    alu_data_i  = 32'hDEAD_BEEF;
    @(negedge clk_i);
    check_eq("alu_only_ready", 32'(alu_ready_o), 32'd1);
    check_eq("alu_only_lsu_ready", 32'(lsu_ready_o), 32'd0);
    next_cycle();
    alu_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("alu_wr_we", 32'(rd_we_o), 32'd1);
    check_eq("alu_wr_addr", 32'(rd_addr_o), 32'd5);
    check_eq("alu_wr_data", rd_data_o, 32'hDEAD_BEEF);
    next_cycle();
    @(negedge clk_i);
    check_eq("alu_after_we", 32'(rd_we_o), 32'd0);
    check_eq("alu_after_addr_hold", 32'(rd_addr_o), 32'd5);

    // x0 filter followed by a write to x31.
    lsu_valid_i = 1'b1;
    lsu_addr_i  = 5'd0;
    lsu_data_i  = 32'h0000_1234;
    @(negedge clk_i);
    check_eq("x0_lsu_ready", 32'(lsu_ready_o), 32'd1);
    next_cycle();
    lsu_addr_i = 5'd31;
    lsu_data_i = 32'hCAFE_0001;
    @(negedge clk_i);
    check_eq("x0_we", 32'(rd_we_o), 32'd0);
    check_eq("x0_addr", 32'(rd_addr_o), 32'd0);
    check_eq("x0_data", rd_data_o, 32'h0000_1234);
    check_eq("x31_lsu_ready", 32'(lsu_ready_o), 32'd1);
    next_cycle();
    lsu_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("x31_we", 32'(rd_we_o), 32'd1);
    check_eq("x31_addr", 32'(rd_addr_o), 32'd31);
    check_eq("x31_data", rd_data_o, 32'hCAFE_0001);

    // Both valid for 20 cycles: fair pattern is LLLLA with counter 0,1,2,3,4; strict is all L.
    next_cycle();
    alu_valid_i = 1'b1;
    alu_addr_i  = 5'd7;
    alu_data_i  = 32'hA1A1_A1A1;
    lsu_valid_i = 1'b1;
    lsu_addr_i  = 5'd9;
    lsu_data_i  = 32'h1515_1515;
    prev_alu    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      phase   = i % 5;
      exp_alu = Fair && (phase == 4);
      @(negedge clk_i);
      if (i > 0) begin
        check_eq($sformatf("both_we_%0d", i), 32'(rd_we_o), 32'd1);
        check_eq($sformatf("both_addr_%0d", i), 32'(rd_addr_o), prev_alu ? 32'd7 : 32'd9);
      end
      check_eq($sformatf("both_alu_ready_%0d", i), 32'(alu_ready_o), 32'(exp_alu));
      check_eq($sformatf("both_lsu_ready_%0d", i), 32'(lsu_ready_o), 32'(!exp_alu));
      check_eq($sformatf("both_cnt_%0d", i), 32'(starve_cnt_o), Fair ? 32'(phase) : 32'd0);
      prev_alu = exp_alu;
      next_cycle();
    end

    // ALU drops out: counter must read 0 afterwards.
    alu_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("last_addr", 32'(rd_addr_o), prev_alu ? 32'd7 : 32'd9);
    check_eq("lsu_alone_ready", 32'(lsu_ready_o), 32'd1);
    next_cycle();
    lsu_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("cnt_clear", 32'(starve_cnt_o), 32'd0);

    // Reset right after an accept drops the held write.
    next_cycle();
    alu_valid_i = 1'b1;
    alu_addr_i  = 5'd12;
    alu_data_i  = 32'h0000_0055;
    next_cycle();
    alu_valid_i = 1'b0;
    rst_i       = 1'b1;
    @(negedge clk_i);
    check_eq("midrst_we_n1", 32'(rd_we_o), 32'd1);
    check_eq("midrst_addr_n1", 32'(rd_addr_o), 32'd12);
    check_eq("midrst_ready", 32'(alu_ready_o | lsu_ready_o), 32'd0);
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("midrst_we_n2", 32'(rd_we_o), 32'd0);
    check_eq("midrst_addr_n2", 32'(rd_addr_o), 32'd0);
    check_eq("midrst_data_n2", rd_data_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
